muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the single-cycle integer ALU in the execute stage. It takes the M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) that the combinational ALU does not implement. Each operation runs over a fixed 34-cycle radix-2 sequence, and the unit uses a valid/ready handshake so the pipeline can stall on it. It holds one operation at a time and supports a pipeline flush.

---
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Latency: fixed 34 edges from accept to result-valid pulse (32 CALC + FIX + DONE).
// Backpressure: md_ready_o low while busy; one operation held; flush aborts silently.
module muldiv_seq (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        md_valid_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] md_data1_i,
  input  logic [31:0] md_data2_i,
  input  logic        md_flush_i,
  output logic        md_ready_o,
  output logic        md_valid_o,
  output logic [31:0] md_result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic        neg_a_q, neg_b_q;
  logic        div0_q, ovf_q;
  logic [31:0] dividend_q;
  logic [31:0] mag_a_q, mag_b_q;
  // Multiply: {product_hi, multiplier}. Divide: {partial remainder, dividend/quotient}.
  logic [63:0] acc_q;
  logic [31:0] result_q;

  logic        accept;
  logic        last_iter;

  // Operand decode at accept time: signedness, negativity and magnitudes
  logic        sgn_a, sgn_b;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        div0, ovf;

  // Per-iteration datapath
  logic [32:0] add_sum;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        trial_ge;
  logic [63:0] acc_step;

  // Sign correction / special-case datapath
  logic [63:0] prod_fix;
  logic [31:0] quo, rem;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] fix_result;

  assign accept    = (state_q == S_IDLE) && md_valid_i && !md_flush_i;
  assign last_iter = (cnt_q == 5'd31);

  // Classify operands of the incoming request
  always_comb begin
    sgn_a = (md_op_i == OP_MULH) || (md_op_i == OP_MULHSU) ||
            (md_op_i == OP_DIV)  || (md_op_i == OP_REM);
    sgn_b = (md_op_i == OP_MULH) || (md_op_i == OP_DIV) || (md_op_i == OP_REM);
    neg_a = sgn_a && md_data1_i[31];
    neg_b = sgn_b && md_data2_i[31];
    mag_a = neg_a ? (~md_data1_i + 32'd1) : md_data1_i;
    mag_b = neg_b ? (~md_data2_i + 32'd1) : md_data2_i;
    div0  = (md_data2_i == 32'd0);
    // Only DIV/REM (op[2]=1, op[0]=0) can overflow
    ovf   = md_op_i[2] && !md_op_i[0] &&
            (md_data1_i == 32'h8000_0000) && (md_data2_i == 32'hFFFF_FFFF);
  end

  // One radix-2 step: shift-add for multiply, restoring trial subtract for divide
  always_comb begin
    add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    shifted  = {acc_q[63:32], acc_q[31]};
    trial    = shifted - {1'b0, mag_b_q};
    // A set top bit means shifted exceeds any 32-bit divisor; otherwise bit 32 is the borrow
    trial_ge = shifted[32] || !trial[32];
    acc_step = {add_sum, acc_q[31:1]};
    if (op_q[2]) begin
      if (trial_ge) begin
        acc_step = {trial[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_step = {shifted[31:0], acc_q[30:0], 1'b0};
      end
    end
  end

  // Final sign correction, special cases and result word selection
  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
    quo      = acc_q[31:0];
    rem      = acc_q[63:32];
    quo_fix  = (neg_a_q ^ neg_b_q) ? (~quo + 32'd1) : quo;
    rem_fix  = neg_a_q ? (~rem + 32'd1) : rem;
    if (div0_q) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = dividend_q;
    end else if (ovf_q) begin
      quo_fix = 32'h8000_0000;
      rem_fix = 32'd0;
    end
    if (op_q[2]) begin
      fix_result = op_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_result = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status outputs, decoded from registered state only
  always_comb begin
    state_d    = state_q;
    md_ready_o = (state_q == S_IDLE);
    md_valid_o = (state_q == S_DONE);
    if (md_flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (md_valid_i) state_d = S_CALC;
        S_CALC: if (last_iter) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand capture on accept and iteration during CALC
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q      <= 5'd0;
      op_q       <= 3'd0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dividend_q <= 32'd0;
      mag_a_q    <= 32'd0;
      mag_b_q    <= 32'd0;
      acc_q      <= 64'd0;
    end else if (accept) begin
      cnt_q      <= 5'd0;
      op_q       <= md_op_i;
      neg_a_q    <= neg_a;
      neg_b_q    <= neg_b;
      div0_q     <= div0;
      ovf_q      <= ovf;
      dividend_q <= md_data1_i;
      mag_a_q    <= mag_a;
      mag_b_q    <= mag_b;
      acc_q      <= {32'd0, (md_op_i[2] ? mag_a : mag_b)};
    end else if ((state_q == S_CALC) && !md_flush_i) begin
      cnt_q <= cnt_q + 5'd1;
      acc_q <= acc_step;
    end
  end

  // Result register: updated only when FIX completes without a flush
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q <= 32'd0;
    end else if ((state_q == S_FIX) && !md_flush_i) begin
      result_q <= fix_result;
    end
  end

  assign md_result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
// Checks reset, all eight ops, special cases, latency, held-valid handshake and flush.
// Inputs driven away from the rising edge; outputs sampled 1ns after it or on the falling edge.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] md_data1;
  logic [31:0] md_data2;
  logic        md_flush;
  logic        md_ready;
  logic        md_valid_o;
  logic [31:0] md_result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res;

  muldiv_seq dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .md_valid_i  (md_valid),
    .md_op_i     (md_op),
    .md_data1_i  (md_data1),
    .md_data2_i  (md_data2),
    .md_flush_i  (md_flush),
    .md_ready_o  (md_ready),
    .md_valid_o  (md_valid_o),
    .md_result_o (md_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op and check the pulse appears after exactly 33 edges past the accept edge
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int early;
    early = 0;
    @(negedge clk);
    check({tag, " ready"}, {63'd0, md_ready}, 64'd1);
    md_valid = 1'b1;
    md_op    = op;
    md_data1 = a;
    md_data2 = b;
    @(posedge clk); #1;
    md_valid = 1'b0;
    check({tag, " busy"}, {63'd0, md_ready}, 64'd0);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      if (md_valid_o) early++;
    end
    check({tag, " early"}, early, 0);
    @(posedge clk); #1;
    check({tag, " pulse"}, {63'd0, md_valid_o}, 64'd1);
    check({tag, " result"}, {32'd0, md_result}, {32'd0, exp});
    @(posedge clk); #1;
    check({tag, " pulse end"}, {63'd0, md_valid_o}, 64'd0);
    check({tag, " idle"}, {63'd0, md_ready}, 64'd1);
    check({tag, " held"}, {32'd0, md_result}, {32'd0, exp});
    last_res = exp;
  endtask

  // Count pulses over a fixed window
  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (md_valid_o) n++;
    end
  endtask

  initial begin
    int pulses;
    int accepts;
    int hs_pulses;
    int cyc;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    rst_n    = 1'b1;
    md_valid = 1'b0;
    md_op    = 3'd0;
    md_data1 = 32'd0;
    md_data2 = 32'd0;
    md_flush = 1'b0;
    last_res = 32'd0;

    #2 rst_n = 1'b0;
    #3;
    check("rst ready", {63'd0, md_ready}, 64'd1);
    check("rst valid", {63'd0, md_valid_o}, 64'd0);
    check("rst result", {32'd0, md_result}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Multiply
    do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Divide
    do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("divu",   3'b101, 32'd100, 32'd7, 32'd14);
    do_op("remu",   3'b111, 32'd100, 32'd7, 32'd2);
    // Special cases
    do_op("div0",   3'b100, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    do_op("rem0",   3'b110, 32'h0000_1234, 32'd0, 32'h0000_1234);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Held valid with operands changing every cycle; MUL low word as the reference
    accepts   = 0;
    hs_pulses = 0;
    for (cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (md_valid_o) begin
        hs_pulses++;
        if (exp_q.size() == 0) begin
          check("hs extra pulse", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hs result", {32'd0, md_result}, {32'd0, e});
          last_res = e;
        end
      end
      md_valid = 1'b1;
      md_op    = 3'b000;
      md_data1 = cyc * 32'h0101_0101 + 32'd7;
      md_data2 = cyc * 32'd3 + 32'd5;
      if (md_ready) begin
        accepts++;
        e = md_data1 * md_data2;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    md_valid = 1'b0;
    if (md_valid_o) begin
      hs_pulses++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("hs result", {32'd0, md_result}, {32'd0, e});
        last_res = e;
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_valid_o) begin
        hs_pulses++;
        if (exp_q.size() == 0) begin
          check("hs extra pulse", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hs result", {32'd0, md_result}, {32'd0, e});
          last_res = e;
        end
      end
    end
    check("hs accepts>=4", {63'd0, accepts >= 4}, 64'd1);
    check("hs one pulse per accept", hs_pulses, accepts);
    check("hs drained", exp_q.size(), 0);

    // Flush at edge E10 of a DIV
    @(negedge clk);
    md_valid = 1'b1;
    md_op    = 3'b100;
    md_data1 = 32'd100;
    md_data2 = 32'd7;
    @(posedge clk); #1;
    md_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 md_flush = 1'b1;
    @(posedge clk); #1;
    md_flush = 1'b0;
    check("flush ready", {63'd0, md_ready}, 64'd1);
    check("flush result kept", {32'd0, md_result}, {32'd0, last_res});
    count_pulses(40, pulses);
    check("flush no pulse", pulses, 0);
    check("flush result still kept", {32'd0, md_result}, {32'd0, last_res});

    // Flush coincident with a request in IDLE
    @(negedge clk);
    md_valid = 1'b1;
    md_flush = 1'b1;
    md_op    = 3'b011;
    md_data1 = 32'hFFFF_FFFF;
    md_data2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    md_valid = 1'b0;
    md_flush = 1'b0;
    check("flush+valid not accepted", {63'd0, md_ready}, 64'd1);
    count_pulses(40, pulses);
    check("flush+valid no pulse", pulses, 0);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    md_valid = 1'b1;
    md_op    = 3'b011;
    md_data1 = 32'hFFFF_FFFF;
    md_data2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    md_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst valid", {63'd0, md_valid_o}, 64'd0);
    check("midrst ready", {63'd0, md_ready}, 64'd1);
    check("midrst result", {32'd0, md_result}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    count_pulses(40, pulses);
    check("midrst no pulse", pulses, 0);
    check("midrst result stays 0", {32'd0, md_result}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
